logic_unit_pipe: RTL and testbench

//   Parametrised, pipelined bitwise logic unit for the EX stage of the pipelined CPU.

---
 rtl/logic_unit_pipe_if.sv | 31 +++
 rtl/logic_unit_pipe.sv | 100 ++++++++++
 tb/tb_logic_unit_pipe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Bundle of the logic unit's handshake and data signals: issue side
// (a/b/op with valid/ready), result side (o/zero with valid/ready),
// the hazard-unit flush and the occupancy count.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OCCW  = 3
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             zero;
  logic [OCCW-1:0]  occ;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, o, zero, occ
  );

  // The logic unit itself.
  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, o, zero, occ
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit for the EX stage. The result and its zero
// flag are computed in front of stage 0 and then carried unchanged through
// STAGES register stages. Each stage has its own valid bit, and the ready
// chain lets empty stages fill even when the output is stalled. Flush drops
// every in-flight op; reset drops them asynchronously.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int OCCW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  logic_unit_pipe_if.slave bus
);

  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [STAGES-1:0] z_q;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  res_d;
  logic              zero_d;
  logic [OCCW-1:0]   occ_d;
  logic              accept;

  // Op decode: result and zero flag ahead of the stage 0 register.
  always_comb begin
    res_d = '0;
    case (bus.op)
      3'b000: res_d = bus.a & bus.b;
      3'b001: res_d = bus.a | bus.b;
      3'b010: res_d = bus.a ^ bus.b;
      3'b011: res_d = ~(bus.a | bus.b);
      3'b100: res_d = bus.a & ~bus.b;
      3'b101: res_d = bus.a | ~bus.b;
      3'b110: res_d = bus.a;
      3'b111: res_d = ~bus.a;
      default: res_d = '0;
    endcase
    zero_d = ~|res_d;
  end

  // Ready chain from the output back to stage 0: a stage can take new data
  // when it is empty or its current contents move on this cycle.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !v_q[STAGES-1] | bus.out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      rdy[i] = !v_q[i] | rdy[i+1];
    end
  end

  assign bus.in_ready = rdy[0] & !bus.flush & !rst;
  assign accept       = bus.in_valid & bus.in_ready;

  // Stage registers: load on accept/advance, hold when stalled, flush kills valids only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      z_q <= '1;
      for (int i = 0; i < STAGES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      if (bus.flush) begin
        v_q[0] <= 1'b0;
      end else if (rdy[0]) begin
        v_q[0] <= accept;
      end
      if (accept) begin
        r_q[0] <= res_d;
        z_q[0] <= zero_d;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (bus.flush) begin
          v_q[i] <= 1'b0;
        end else if (rdy[i]) begin
          v_q[i] <= v_q[i-1];
        end
        if (v_q[i-1] && rdy[i]) begin
          r_q[i] <= r_q[i-1];
          z_q[i] <= z_q[i-1];
        end
      end
    end
  end

  // Occupancy: number of stages currently holding a valid op.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCCW'(v_q[i]);
    end
  end

  assign bus.occ       = occ_d;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.o         = r_q[STAGES-1];
  assign bus.zero      = z_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 32-bit/2-stage unit for the main
// function, plus 8-bit units with 1 and 4 stages for latency and flush.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_tx;
  int   n_rx;

  logic_unit_pipe_if #(.WIDTH(32), .OCCW(3)) bus0 ();
  logic_unit_pipe_if #(.WIDTH(8),  .OCCW(3)) bus1 ();
  logic_unit_pipe_if #(.WIDTH(8),  .OCCW(3)) bus4 ();

  logic_unit_pipe #(.WIDTH(32), .STAGES(2), .OCCW(3)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  logic_unit_pipe #(.WIDTH(8),  .STAGES(1), .OCCW(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  logic_unit_pipe #(.WIDTH(8),  .STAGES(4), .OCCW(3)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_exp [8];

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Hand-computed for a=F0F0_1234, b=0FF0_FFFF (~b = F00F_0000).
    sweep_exp[0] = 32'h00F0_1234;  // a & b
    sweep_exp[1] = 32'hFFF0_FFFF;  // a | b
    sweep_exp[2] = 32'hFF00_EDCB;  // a ^ b
    sweep_exp[3] = 32'h000F_0000;  // ~(a | b)
    sweep_exp[4] = 32'hF000_0000;  // a & ~b
    sweep_exp[5] = 32'hF0FF_1234;  // a | ~b
    sweep_exp[6] = 32'hF0F0_1234;  // a
    sweep_exp[7] = 32'h0F0F_EDCB;  // ~a

    rst = 1'b1;
    bus0.flush = 0; bus0.in_valid = 0; bus0.op = 0; bus0.a = 0; bus0.b = 0; bus0.out_ready = 1;
    bus1.flush = 0; bus1.in_valid = 0; bus1.op = 0; bus1.a = 0; bus1.b = 0; bus1.out_ready = 1;
    bus4.flush = 0; bus4.in_valid = 0; bus4.op = 0; bus4.a = 0; bus4.b = 0; bus4.out_ready = 1;

    // Reset state
    #3;
    check("rst_out_valid", 32'(bus0.out_valid), 0);
    check("rst_o", bus0.o, 0);
    check("rst_zero", 32'(bus0.zero), 1);
    check("rst_occ", 32'(bus0.occ), 0);
    check("rst_in_ready", 32'(bus0.in_ready), 0);
    #10 rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus0.in_ready), 1);
    step();

    // Ops sweep, full-rate stream
    bus0.out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      bus0.in_valid = 1; bus0.op = 3'(k); bus0.a = 32'hF0F0_1234; bus0.b = 32'h0FF0_FFFF;
      #1;
      check("sweep_in_ready", 32'(bus0.in_ready), 1);
      step();
      if (k == 0) begin
        check("sweep_latency", 32'(bus0.out_valid), 0);
      end else begin
        check("sweep_valid", 32'(bus0.out_valid), 1);
        check("sweep_o", bus0.o, sweep_exp[k-1]);
        check("sweep_zero", 32'(bus0.zero), 0);
      end
    end
    bus0.in_valid = 0;
    step();
    check("sweep_last_o", bus0.o, sweep_exp[7]);
    check("sweep_last_valid", 32'(bus0.out_valid), 1);
    step();
    check("sweep_drained", 32'(bus0.out_valid), 0);

    // Zero flag
    bus0.in_valid = 1; bus0.op = 3'b010; bus0.a = 32'hDEAD_BEEF; bus0.b = 32'hDEAD_BEEF;
    step();
    bus0.in_valid = 0;
    step();
    check("zero_valid", 32'(bus0.out_valid), 1);
    check("zero_o", bus0.o, 0);
    check("zero_flag", 32'(bus0.zero), 1);
    step();

    // Backpressure: 5 ops, output stalled for cycles 3..7
    n_tx = 0; n_rx = 0;
    bus0.op = 3'b110; bus0.b = 32'h0;
    for (int c = 0; c < 40 && n_rx < 5; c++) begin
      bus0.in_valid  = (n_tx < 5);
      bus0.a         = 32'h1000_0000 + 32'(n_tx);
      bus0.out_ready = !(c >= 3 && c < 8);
      #1;
      if (c >= 3 && c < 8) begin
        check("bp_occ", 32'(bus0.occ), 2);
        check("bp_in_ready", 32'(bus0.in_ready), 0);
        check("bp_o_held", bus0.o, 32'h1000_0001);
      end
      if (bus0.in_valid && bus0.in_ready) n_tx++;
      if (bus0.out_valid && bus0.out_ready) begin
        check("bp_order", bus0.o, 32'h1000_0000 + 32'(n_rx));
        n_rx++;
      end
      step();
    end
    bus0.in_valid = 0;
    check("bp_count", 32'(n_rx), 5);
    check("bp_no_dup", 32'(bus0.out_valid), 0);
    check("bp_occ_empty", 32'(bus0.occ), 0);

    // Bubble collapse
    bus0.out_ready = 0;
    bus0.in_valid = 1; bus0.a = 32'h0000_0055;
    step();
    bus0.in_valid = 0;
    step();
    check("bub_occ1", 32'(bus0.occ), 1);
    check("bub_valid", 32'(bus0.out_valid), 1);
    check("bub_o", bus0.o, 32'h55);
    check("bub_in_ready", 32'(bus0.in_ready), 1);
    bus0.in_valid = 1; bus0.a = 32'h0000_0066;
    step();
    bus0.in_valid = 0;
    check("bub_occ2", 32'(bus0.occ), 2);
    check("bub_full", 32'(bus0.in_ready), 0);
    check("bub_o_held", bus0.o, 32'h55);
    bus0.out_ready = 1;
    step();
    check("bub_drain1", bus0.o, 32'h66);
    check("bub_drain1_v", 32'(bus0.out_valid), 1);
    step();
    check("bub_drain2_v", 32'(bus0.out_valid), 0);

    // Flush with two ops in flight, STAGES=2
    bus0.in_valid = 1; bus0.a = 32'h0000_0011;
    step();
    bus0.a = 32'h0000_0022;
    step();
    check("fl2_occ", 32'(bus0.occ), 2);
    bus0.flush = 1; bus0.a = 32'h0000_0033;
    #1;
    check("fl2_in_ready", 32'(bus0.in_ready), 0);
    step();
    bus0.flush = 0; bus0.in_valid = 0;
    check("fl2_occ0", 32'(bus0.occ), 0);
    check("fl2_valid0", 32'(bus0.out_valid), 0);
    step();
    check("fl2_no_leak", 32'(bus0.out_valid), 0);

    // STAGES=1 latency: a | ~b = 0F | 0F = 0F
    bus1.in_valid = 1; bus1.op = 3'b101; bus1.a = 8'h0F; bus1.b = 8'hF0;
    step();
    bus1.in_valid = 0;
    check("s1_valid", 32'(bus1.out_valid), 1);
    check("s1_o", 32'(bus1.o), 32'h0F);
    step();
    check("s1_drained", 32'(bus1.out_valid), 0);

    // STAGES=1 flush
    bus1.out_ready = 0; bus1.in_valid = 1; bus1.op = 3'b110; bus1.a = 8'hA5;
    step();
    bus1.in_valid = 0;
    check("s1_fl_occ", 32'(bus1.occ), 1);
    bus1.flush = 1; bus1.in_valid = 1; bus1.out_ready = 1;
    #1;
    check("s1_fl_in_ready", 32'(bus1.in_ready), 0);
    step();
    bus1.flush = 0; bus1.in_valid = 0;
    check("s1_fl_occ0", 32'(bus1.occ), 0);
    check("s1_fl_valid0", 32'(bus1.out_valid), 0);

    // STAGES=4 latency: ~(0F | 30) = C0
    bus4.in_valid = 1; bus4.op = 3'b011; bus4.a = 8'h0F; bus4.b = 8'h30;
    step();
    bus4.in_valid = 0;
    for (int s = 0; s < 2; s++) begin
      check("s4_latency", 32'(bus4.out_valid), 0);
      step();
    end
    check("s4_latency", 32'(bus4.out_valid), 0);
    step();
    check("s4_valid", 32'(bus4.out_valid), 1);
    check("s4_o", 32'(bus4.o), 32'hC0);
    check("s4_zero", 32'(bus4.zero), 0);
    step();

    // STAGES=4 flush
    bus4.out_ready = 0; bus4.op = 3'b110; bus4.in_valid = 1; bus4.a = 8'h11;
    step();
    bus4.a = 8'h22;
    step();
    bus4.in_valid = 0;
    check("s4_fl_occ", 32'(bus4.occ), 2);
    bus4.flush = 1; bus4.in_valid = 1; bus4.out_ready = 1;
    #1;
    check("s4_fl_in_ready", 32'(bus4.in_ready), 0);
    step();
    bus4.flush = 0; bus4.in_valid = 0;
    check("s4_fl_occ0", 32'(bus4.occ), 0);
    for (int s = 0; s < 5; s++) begin
      check("s4_fl_no_leak", 32'(bus4.out_valid), 0);
      step();
    end

    // Reset mid-stream
    bus0.out_ready = 0; bus0.in_valid = 1; bus0.a = 32'h0000_0077;
    step();
    step();
    check("mrst_occ_before", 32'(bus0.occ), 2);
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 32'(bus0.out_valid), 0);
    check("mrst_occ", 32'(bus0.occ), 0);
    check("mrst_in_ready", 32'(bus0.in_ready), 0);
    check("mrst_zero", 32'(bus0.zero), 1);
    bus0.in_valid = 0;
    #4 rst = 1'b0;
    #1;
    check("mrst_rel_in_ready", 32'(bus0.in_ready), 1);
    step();
    check("mrst_no_output", 32'(bus0.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
